// File: rtl/cpu_6502_pkg.sv
// Shared types and defaults for the 6502 front end: fetch FSM states,
// the reset vector location and the bus widths also used by decode_stage.
package cpu_6502_pkg;

    typedef enum logic [1:0] {
        VEC_LO   = 2'd0,
        VEC_HI   = 2'd1,
        VEC_WAIT = 2'd2,
        RUN      = 2'd3
    } fetch_state_t;

    localparam logic [15:0] VEC_RESET  = 16'hFFFC;
    localparam int          CPU_ADDR_W = 16;
    localparam int          CPU_DATA_W = 8;

endpackage

// File: rtl/fetch_byte_fifo.sv
// Circular FIFO of {address, byte} entries between the fetch unit and decode.
// A flush empties it in one cycle and wins over a push or pop in that cycle.
module fetch_byte_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [W-1:0]     o_dout,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop = i_pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (i_push && !w_do_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!i_push && w_do_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush)
            r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/cpu_fetch_queue.sv
// Instruction-fetch front end: boots the PC from the reset vector, prefetches
// address-tagged bytes into a small queue and drops in-flight data on redirect.
module cpu_fetch_queue
    import cpu_6502_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter int                DEPTH    = 4,
    parameter bit                VEC_EN   = 1'b1,
    parameter logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(VEC_RESET),
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic              mem_grant,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = ADDR_W + DATA_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_tag;
    logic              r_inflight;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_rd_en;
    logic              w_accept;
    logic              w_room;
    logic              w_push;
    logic              w_flush;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count;
    logic [W-1:0]      w_head;

    // Reserve a slot for the response still on the bus so a push never finds the queue full.
    assign w_room = ({1'b0, w_count} + (CNT_W + 1)'(r_inflight)) < (CNT_W + 1)'(DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_mem_addr  = r_fetch_pc;
        case (r_state)
            VEC_LO: begin
                w_rd_en    = 1'b1;
                w_mem_addr = VEC_ADDR;
                if (mem_grant)
                    w_state_nxt = VEC_HI;
            end
            VEC_HI: begin
                w_rd_en    = 1'b1;
                w_mem_addr = VEC_ADDR + ADDR_W'(1);
                if (mem_grant)
                    w_state_nxt = VEC_WAIT;
            end
            VEC_WAIT: w_state_nxt = RUN;
            RUN:      w_rd_en = w_room & ~redirect_valid;
            default:  w_state_nxt = r_state;
        endcase
        if (!rst_n) begin
            w_rd_en    = 1'b0;
            w_mem_addr = VEC_EN ? VEC_ADDR : RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= VEC_EN ? VEC_LO : RUN;
        else
            r_state <= w_state_nxt;
    end

    assign w_accept = w_rd_en & mem_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_inflight <= w_accept;
            case (r_state)
                VEC_HI: begin
                    if (r_inflight)
                        r_fetch_pc[DATA_W-1:0] <= mem_rdata;
                end
                VEC_WAIT: r_fetch_pc[ADDR_W-1:DATA_W] <= (ADDR_W - DATA_W)'(mem_rdata);
                RUN: begin
                    if (redirect_valid)
                        r_fetch_pc <= redirect_addr;
                    else if (w_accept)
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                end
                default: r_fetch_pc <= r_fetch_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_tag <= r_fetch_pc;
    end

    // A response returning in a redirect cycle belongs to the old path and is dropped.
    assign w_push  = (r_state == RUN) & r_inflight & ~redirect_valid;
    assign w_flush = (r_state == RUN) & redirect_valid;
    assign w_pop   = out_valid & out_ready;

    fetch_byte_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({r_tag, mem_rdata}),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign mem_addr  = w_mem_addr;
    assign mem_rd_en = w_rd_en;
    assign out_valid = rst_n & (w_count != '0);
    assign out_pc    = w_head[W-1:DATA_W];
    assign out_data  = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue: boot, backpressure, redirect, grant stall,
// PC wrap and mid-run reset against a simple one-cycle-latency memory.
module tb_cpu_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_grant;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_pc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int base;

    cpu_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_grant      (mem_grant),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'h80;
            16'h8000: return 8'hA9;
            16'h8001: return 8'h05;
            default:  return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // Memory: data for an accepted request appears one cycle later; otherwise junk.
    always @(posedge clk) begin
        if (mem_rd_en && mem_grant) begin
            mem_rdata <= mem_byte(mem_addr);
            acc_cnt   <= acc_cnt + 1;
        end else begin
            mem_rdata <= 8'hEE;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_grant      = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        step();
        step();
        chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'hFFFC);

        // Boot: cycle 0 is the first cycle with rst_n high
        rst_n = 1'b1;
        #1;
        chk("boot_c0_en", 32'(mem_rd_en), 32'h1);
        chk("boot_c0_addr", 32'(mem_addr), 32'hFFFC);
        step();
        chk("boot_c1_en", 32'(mem_rd_en), 32'h1);
        chk("boot_c1_addr", 32'(mem_addr), 32'hFFFD);
        step();
        chk("boot_c2_en", 32'(mem_rd_en), 32'h0);
        step();
        chk("boot_c3_en", 32'(mem_rd_en), 32'h1);
        chk("boot_c3_addr", 32'(mem_addr), 32'h8000);
        step();
        chk("boot_c4_valid", 32'(out_valid), 32'h0);
        step();
        chk("boot_c5_valid", 32'(out_valid), 32'h1);
        chk("boot_c5_pc", 32'(out_pc), 32'h8000);
        chk("boot_c5_data", 32'(out_data), 32'hA9);
        step();
        chk("boot_c6_pc", 32'(out_pc), 32'h8001);
        chk("boot_c6_data", 32'(out_data), 32'h05);

        // Backpressure: redirect to 4000 with decode stalled
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h4000;
        #1;
        base = acc_cnt;
        step();
        redirect_valid = 1'b0;
        repeat (7) step();
        chk("bp_accepts", 32'(acc_cnt - base), 32'd4);
        chk("bp_rd_en", 32'(mem_rd_en), 32'h0);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_pc0", 32'(out_pc), 32'h4000);
        chk("bp_data0", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        step();
        chk("bp_pc1", 32'(out_pc), 32'h4001);
        chk("bp_data1", 32'(out_data), 32'h3D);
        step();
        chk("bp_pc2", 32'(out_pc), 32'h4002);
        step();
        chk("bp_pc3", 32'(out_pc), 32'h4003);
        chk("bp_data3", 32'(out_data), 32'h3F);

        // Redirect to 8000 (cycle t), then to 1234 while 8003 is in flight
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 16'h8000;
        #1;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("rd_t3_valid", 32'(out_valid), 32'h1);
        chk("rd_t3_pc", 32'(out_pc), 32'h8000);
        step();
        chk("rd_t4_en", 32'(mem_rd_en), 32'h1);
        chk("rd_t4_addr", 32'(mem_addr), 32'h8003);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 16'h1234;
        #1;
        chk("rd_t5_en", 32'(mem_rd_en), 32'h0);
        step();
        redirect_valid = 1'b0;
        chk("rd_t6_valid", 32'(out_valid), 32'h0);
        step();
        chk("rd_t7_valid", 32'(out_valid), 32'h0);
        step();
        chk("rd_t8_valid", 32'(out_valid), 32'h1);
        chk("rd_t8_pc", 32'(out_pc), 32'h1234);
        chk("rd_t8_data", 32'(out_data), 32'h08);
        step();
        chk("rd_t9_pc", 32'(out_pc), 32'h1235);
        chk("rd_t9_data", 32'(out_data), 32'h09);

        // Grant stall for 5 cycles
        mem_grant = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_en", 32'(mem_rd_en), 32'h1);
            chk("stall_addr", 32'(mem_addr), 32'h1237);
            if (i >= 2)
                chk("stall_no_push", 32'(out_valid), 32'h0);
            step();
        end
        mem_grant = 1'b1;
        #1;
        chk("resume_addr", 32'(mem_addr), 32'h1237);
        step();
        chk("resume_next_addr", 32'(mem_addr), 32'h1238);
        step();
        chk("resume_valid", 32'(out_valid), 32'h1);
        chk("resume_pc", 32'(out_pc), 32'h1237);
        chk("resume_data", 32'(out_data), 32'h0B);

        // Wrap around FFFF
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFE;
        #1;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("wrap_pc0", 32'(out_pc), 32'hFFFE);
        chk("wrap_data0", 32'(out_data), 32'hC2);
        step();
        chk("wrap_pc1", 32'(out_pc), 32'hFFFF);
        step();
        chk("wrap_pc2", 32'(out_pc), 32'h0000);
        chk("wrap_data2", 32'(out_data), 32'h3C);
        step();
        chk("wrap_pc3", 32'(out_pc), 32'h0001);
        chk("wrap_valid3", 32'(out_valid), 32'h1);

        // Reset with three bytes queued and one response returning
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h2000;
        #1;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        chk("mr_full_en", 32'(mem_rd_en), 32'h0);
        chk("mr_head_pc", 32'(out_pc), 32'h2000);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_valid", 32'(out_valid), 32'h0);
        chk("mr_rst_en", 32'(mem_rd_en), 32'h0);
        chk("mr_rst_addr", 32'(mem_addr), 32'hFFFC);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mr_c0_valid", 32'(out_valid), 32'h0);
        chk("mr_c0_en", 32'(mem_rd_en), 32'h1);
        chk("mr_c0_addr", 32'(mem_addr), 32'hFFFC);
        step();
        step();
        step();
        chk("mr_c3_addr", 32'(mem_addr), 32'h8000);
        step();
        chk("mr_c4_valid", 32'(out_valid), 32'h0);
        step();
        chk("mr_c5_pc", 32'(out_pc), 32'h8000);
        chk("mr_c5_data", 32'(out_data), 32'hA9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_queue.md
# cpu_fetch_queue

Parametrised instruction-fetch front end for the 6502 core, replacing the single-register fetch stage. It loads the start PC from the reset vector, prefetches opcode/operand bytes into a DEPTH-entry queue tagged with their addresses, and hands them to decode through a valid/ready handshake. It yields the memory bus to the execute stage through a grant input and flushes cleanly on jump/branch redirects.

## Interface
- ADDR_W, 16: address width; PC arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8: fetched byte width.
- DEPTH, 4: queue entries, minimum 2; full throughput needs DEPTH >= 3.
- VEC_EN, 1: 1 = PC loaded from the reset vector; 0 = PC starts at RESET_PC.
- VEC_ADDR, 16'hFFFC: low byte address of the reset vector; the high byte is at VEC_ADDR+1.
- RESET_PC, 16'h0000: start PC when VEC_EN=0.
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- mem_addr  out  ADDR_W  fetch address, valid when mem_rd_en=1.
- mem_rd_en  out  1  fetch request.
- mem_grant  in  1  bus free this cycle; a request is accepted when mem_rd_en & mem_grant.
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after acceptance.
- redirect_valid  in  1  jump/branch taken; flush the queue and restart fetch.
- redirect_addr  in  ADDR_W  new fetch PC.
- out_valid  out  1  queue head valid.
- out_data  out  DATA_W  head byte.
- out_pc  out  ADDR_W  address of the head byte.
- out_ready  in  1  decode accepts the head byte; a pop occurs when out_valid & out_ready.

## Operation
- The state machine has four states: VEC_LO, VEC_HI, VEC_WAIT and RUN. Reset enters VEC_LO if VEC_EN=1, otherwise RUN with fetch_pc=RESET_PC.
- VEC_LO: drive mem_addr=VEC_ADDR. On acceptance, go to VEC_HI.
- VEC_HI: drive mem_addr=VEC_ADDR+1. The low byte returns during this state and is written into fetch_pc[7:0]. On acceptance, go to VEC_WAIT.
- VEC_WAIT: no request. The returning byte is written into fetch_pc[15:8], then the FSM goes to RUN.
- Vector states ignore redirect_valid and never write to the queue.
- RUN issue rule: mem_rd_en = (count + inflight < DEPTH) & ~redirect_valid.
  - mem_addr = fetch_pc.
  - On acceptance, fetch_pc increments (FFFF wraps to 0000) and inflight is set with a tag of fetch_pc.
- Response: in the cycle after acceptance, {tag, mem_rdata} is pushed into the queue unless the request has been flushed.
- Redirect (RUN only), in the cycle redirect_valid=1:
  - count clears to 0;
  - any in-flight response is marked stale and dropped when it returns;
  - fetch_pc is loaded with redirect_addr;
  - a pop in the same cycle is discarded (decode must ignore it).
- Simultaneous push and pop: both take effect and count is unchanged.
- The issue rule guarantees a push never hits a full queue. No overflow or underflow is possible.
- mem_grant low: the request is held stable (same mem_addr) until it is granted or a redirect occurs.
- mem_rd_en depends on state, count, inflight and redirect_valid only. It never depends on mem_grant or out_ready, so no combinational loops exist.

## Timing
- Reset state: state=VEC_LO (or RUN), count=0, inflight=0, stale=0.
- Outputs while rst_n=0:
  - mem_rd_en=0, out_valid=0;
  - out_data and out_pc are don't-care;
  - mem_addr = VEC_ADDR when VEC_EN=1, otherwise RESET_PC.
- Reset mid-operation discards the queue and any in-flight response. The vector fetch restarts in the first cycle after rst_n rises.
- Redirect latency: redirect at cycle t; request at t+1 if granted; data captured at t+2; out_valid=1 with out_pc=redirect_addr at t+3.
- Vector boot with continuous grant: VEC_ADDR requested at cycle 0, VEC_ADDR+1 at cycle 1, first RUN request at cycle 3, first out_valid at cycle 5.
- Steady state with DEPTH >= 3 and constant grant/ready: one byte per cycle.

## Structure
- Package cpu_6502_pkg holds:
  - the fetch state enum (VEC_LO, VEC_HI, VEC_WAIT, RUN);
  - default constant VEC_RESET = 16'hFFFC;
  - an ADDR_W/DATA_W default pair shared with decode_stage.
- Sub-module fetch_byte_fifo: synchronous DEPTH x (ADDR_W+DATA_W) FIFO with push, pop, a single-cycle flush and a count output, with wrap-around read/write pointers. The top level contains the FSM, the issue logic, the inflight/stale tracking and fetch_pc.

## Test plan
- Boot: memory FFFC=0x00, FFFD=0x80, 8000=A9, 8001=05, constant grant and ready -> addresses FFFC, FFFD, 8000 issued at cycles 0, 1, 3; out (8000,A9) at cycle 5, then (8001,05).
- Backpressure: out_ready=0 with DEPTH=4 -> exactly 4 requests accepted, mem_rd_en then held 0; raising out_ready drains bytes in order with consecutive out_pc.
- Redirect with an in-flight request: redirect to 0x1234 in the cycle after an acceptance at 0x8003 -> the 0x8003 byte is never presented; next out_pc=0x1234, three cycles after the redirect.
- Grant stall: mem_grant=0 for 5 cycles in RUN -> mem_addr held constant, fetch_pc not incremented, no push; fetch resumes on the first granted cycle.
- Wrap: redirect to 0xFFFE -> out_pc sequence FFFE, FFFF, 0000, 0001.
- Reset mid-run with a full queue and inflight=1 -> out_valid=0 the next cycle, the stale byte is not pushed, and FFFC is the first address requested after rst_n rises.
